// File: rtl/vending_machine_pkg.sv
// Shared definitions for the vending machine: transaction modes, default prices,
// and the 7-segment pattern table.
package vending_machine_pkg;

    typedef enum logic [1:0] {
        PURCHASE  = 2'd0,
        RESTOCK   = 2'd1,
        SET_PRICE = 2'd2,
        QUERY     = 2'd3
    } mode_e;

    localparam int PRICE_W = 4;
    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    localparam logic [PRICE_W-1:0] DEFAULT_PRICE [4] = '{4'd3, 4'd4, 4'd5, 4'd6};
    localparam logic [PRICE_W-1:0] DEFAULT_PRICE_OTHER = 4'd7;

    // Bit 0 is segment a through bit 6 segment g; a lit segment is 1.
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [SEG_W-1:0] BLANK = 7'h00;

    function automatic logic [PRICE_W-1:0] default_price(input int slot);
        if (slot >= 0 && slot < 4) begin
            return DEFAULT_PRICE[slot[1:0]];
        end
        return DEFAULT_PRICE_OTHER;
    endfunction

endpackage

// File: rtl/vending_machine_seg7_decoder.sv
// Combinational hex digit to 7-segment pattern (active-high); the top level
// registers and optionally inverts the result.
module seg7_decoder
    import vending_machine_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    output logic [SEG_W-1:0]   pattern
);

    always_comb begin
        pattern = HEX_SEG[value];
    end

endmodule

// File: rtl/vending_machine.sv
// Vending-machine controller: one purchase/restock/set-price/query transaction per
// clock edge. Define VENDING_MACHINE_SEG_ACTIVE_LOW_EN for active-low segment outputs.
module vending_machine
    import vending_machine_pkg::*;
#(
    parameter int NUM_TYPES  = 4,
    parameter int STOCK_W    = 6,
    parameter int INIT_STOCK = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [3:0]         in_money,
    input  logic [3:0]         product_type,
    input  logic [3:0]         number,
    output logic [SEG_W-1:0]   segment,
    output logic               status
);

    localparam int IDX_W = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1;
    localparam logic [31:0] STOCK_MAX = (32'd1 << STOCK_W) - 32'd1;

`ifdef VENDING_MACHINE_SEG_ACTIVE_LOW_EN
    localparam logic [SEG_W-1:0] SEG_MASK = 7'h7F;
`else
    localparam logic [SEG_W-1:0] SEG_MASK = 7'h00;
`endif
    localparam logic [SEG_W-1:0] SEG_RESET = BLANK ^ SEG_MASK;

    logic [STOCK_W-1:0] stock [NUM_TYPES];
    logic [PRICE_W-1:0] price [NUM_TYPES];

    mode_e              op;
    logic               type_ok;
    logic [IDX_W-1:0]   idx;
    logic [STOCK_W-1:0] cur_stock;
    logic [PRICE_W-1:0] cur_price;
    logic [7:0]         cost;
    logic [31:0]        stock_wide;
    logic [31:0]        restock_sum;
    logic               buy_ok;

    logic [DIGIT_W-1:0] next_digit;
    logic               next_status;
    logic               stock_we;
    logic [STOCK_W-1:0] stock_wdata;
    logic               price_we;
    logic [SEG_W-1:0]   dec_pattern;

    assign op      = mode_e'(mode);
    assign type_ok = ({28'd0, product_type} < 32'(NUM_TYPES));
    assign idx     = type_ok ? product_type[IDX_W-1:0] : '0;

    assign cur_stock = stock[idx];
    assign cur_price = price[idx];

    // Full 8-bit product so a large quantity never wraps into an affordable cost.
    assign cost        = {4'd0, cur_price} * {4'd0, number};
    assign stock_wide  = 32'(cur_stock);
    assign restock_sum = stock_wide + 32'(number);
    assign buy_ok      = (number != 4'd0)
                      && (32'(number) <= stock_wide)
                      && ({4'd0, in_money} >= cost);

    // Transaction decision: what to show, whether it succeeded, and which slot to update.
    always_comb begin
        next_digit  = 4'd0;
        next_status = 1'b0;
        stock_we    = 1'b0;
        stock_wdata = cur_stock;
        price_we    = 1'b0;

        if (!type_ok) begin
            next_digit = (op == PURCHASE) ? in_money : 4'd0;
        end else begin
            case (op)
                PURCHASE: begin
                    if (buy_ok) begin
                        stock_we    = 1'b1;
                        stock_wdata = cur_stock - STOCK_W'(number);
                        next_status = 1'b1;
                        next_digit  = in_money - cost[3:0];
                    end else begin
                        next_digit  = in_money;
                    end
                end
                RESTOCK: begin
                    stock_we    = 1'b1;
                    stock_wdata = (restock_sum > STOCK_MAX) ? STOCK_MAX[STOCK_W-1:0]
                                                            : restock_sum[STOCK_W-1:0];
                    next_status = 1'b1;
                    next_digit  = number;
                end
                SET_PRICE: begin
                    next_digit = in_money;
                    if (in_money != 4'd0) begin
                        price_we    = 1'b1;
                        next_status = 1'b1;
                    end
                end
                QUERY: begin
                    next_status = 1'b1;
                    next_digit  = (stock_wide > 32'd15) ? 4'hF : stock_wide[3:0];
                end
                default: begin
                    next_status = 1'b0;
                end
            endcase
        end
    end

    seg7_decoder u_seg7_decoder (
        .value   (next_digit),
        .pattern (dec_pattern)
    );

    // All architectural state: product tables plus the registered display result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segment <= SEG_RESET;
            status  <= 1'b0;
            for (int i = 0; i < NUM_TYPES; i++) begin
                stock[i] <= STOCK_W'(INIT_STOCK);
                price[i] <= default_price(i);
            end
        end else begin
            segment <= dec_pattern ^ SEG_MASK;
            status  <= next_status;
            if (stock_we) begin
                stock[idx] <= stock_wdata;
            end
            if (price_we) begin
                price[idx] <= in_money;
            end
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: each transaction queues its expected
// status/segment, and a negedge monitor compares them one cycle later.
module tb_vending_machine;
    import vending_machine_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic [3:0] in_money;
    logic [3:0] product_type;
    logic [3:0] number;
    logic [6:0] segment;
    logic       status;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       exp_status;
        logic [6:0] exp_seg;
        string      name;
    } exp_t;

    exp_t sb[$];

    vending_machine #(
        .NUM_TYPES  (4),
        .STOCK_W    (6),
        .INIT_STOCK (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .in_money     (in_money),
        .product_type (product_type),
        .number       (number),
        .segment      (segment),
        .status       (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0: p = 7'b0111111;
            4'h1: p = 7'b0000110;
            4'h2: p = 7'b1011011;
            4'h3: p = 7'b1001111;
            4'h4: p = 7'b1100110;
            4'h5: p = 7'b1101101;
            4'h6: p = 7'b1111101;
            4'h7: p = 7'b0000111;
            4'h8: p = 7'b1111111;
            4'h9: p = 7'b1101111;
            4'hA: p = 7'b1110111;
            4'hB: p = 7'b1111100;
            4'hC: p = 7'b0111001;
            4'hD: p = 7'b1011110;
            4'hE: p = 7'b1111001;
            default: p = 7'b1110001;
        endcase
`ifdef VENDING_MACHINE_SEG_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    function automatic logic [6:0] seg_blank();
`ifdef VENDING_MACHINE_SEG_ACTIVE_LOW_EN
        return 7'h7F;
`else
        return 7'h00;
`endif
    endfunction

    // Monitor: everything queued at a rising edge is due by the following falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (status !== e.exp_status) begin
                errors++;
                $display("[TB] FAIL %s status actual %0b expected %0b", e.name, status, e.exp_status);
            end
            checks++;
            if (segment !== e.exp_seg) begin
                errors++;
                $display("[TB] FAIL %s segment actual %h expected %h", e.name, segment, e.exp_seg);
            end
        end
    end

    task automatic drive_txn(input mode_e m, input logic [3:0] money, input logic [3:0] t,
                             input logic [3:0] n, input logic exp_st,
                             input logic [3:0] exp_digit, input string name);
        exp_t e;
        @(negedge clk);
        mode         = m;
        in_money     = money;
        product_type = t;
        number       = n;
        @(posedge clk);
        e.exp_status = exp_st;
        e.exp_seg    = seg_of(exp_digit);
        e.name       = name;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (segment !== seg_blank()) begin
            errors++;
            $display("[TB] FAIL reset_segment actual %h expected %h", segment, seg_blank());
        end
        checks++;
        if (status !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status actual %0b expected 0", status);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_purchase();
        drive_txn(PURCHASE, 4'd9, 4'd0, 4'd1, 1'b1, 4'h6, "buy_t0_change6");
        drive_txn(PURCHASE, 4'd9, 4'd0, 4'd1, 1'b0, 4'h9, "buy_t0_empty_refund");
        drive_txn(QUERY,    4'd0, 4'd0, 4'd0, 1'b1, 4'h0, "query_t0_empty");
    endtask

    task automatic test_restock();
        drive_txn(RESTOCK, 4'd0, 4'd0, 4'd15, 1'b1, 4'hF, "restock_t0_15");
        drive_txn(RESTOCK, 4'd0, 4'd0, 4'd4,  1'b1, 4'h4, "restock_t0_4");
        drive_txn(QUERY,   4'd0, 4'd0, 4'd0,  1'b1, 4'hF, "query_t0_clamp19");
        for (int i = 0; i < 4; i++) begin
            drive_txn(RESTOCK, 4'd0, 4'd0, 4'd15, 1'b1, 4'hF, "restock_t0_sat");
        end
        drive_txn(QUERY, 4'd0, 4'd0, 4'd0, 1'b1, 4'hF, "query_t0_sat");
        // Drain the saturated slot 15 at a time to expose its exact count of 63.
        drive_txn(SET_PRICE, 4'd1, 4'd0, 4'd0, 1'b1, 4'h1, "price_t0_1");
        for (int i = 0; i < 4; i++) begin
            drive_txn(PURCHASE, 4'd15, 4'd0, 4'd15, 1'b1, 4'h0, "buy_t0_15");
        end
        drive_txn(QUERY, 4'd0, 4'd0, 4'd0, 1'b1, 4'h3, "query_t0_after_drain");
    endtask

    task automatic test_stock_limit();
        drive_txn(PURCHASE, 4'd13, 4'd3, 4'd2, 1'b0, 4'hD, "buy_t3_short_stock");
        drive_txn(RESTOCK,  4'd0,  4'd3, 4'd1, 1'b1, 4'h1, "restock_t3_1");
        drive_txn(PURCHASE, 4'd13, 4'd3, 4'd2, 1'b1, 4'h1, "buy_t3_two");
        drive_txn(QUERY,    4'd0,  4'd3, 4'd0, 1'b1, 4'h0, "query_t3_empty");
    endtask

    task automatic test_set_price();
        drive_txn(SET_PRICE, 4'd2,  4'd3, 4'd0, 1'b1, 4'h2, "price_t3_2");
        drive_txn(RESTOCK,   4'd0,  4'd3, 4'd1, 1'b1, 4'h1, "restock_t3_again");
        drive_txn(PURCHASE,  4'd2,  4'd3, 4'd1, 1'b1, 4'h0, "buy_t3_new_price");
        drive_txn(PURCHASE,  4'd11, 4'd1, 4'd3, 1'b0, 4'hB, "buy_t1_cost12");
        drive_txn(PURCHASE,  4'd4,  4'd2, 4'd1, 1'b0, 4'h4, "buy_t2_short_money");
        drive_txn(PURCHASE,  4'd5,  4'd2, 4'd1, 1'b1, 4'h0, "buy_t2_exact_money");
    endtask

    task automatic test_invalid();
        drive_txn(PURCHASE,  4'd7,  4'd5,  4'd1, 1'b0, 4'h7, "bad_type_buy");
        drive_txn(RESTOCK,   4'd0,  4'd5,  4'd3, 1'b0, 4'h0, "bad_type_restock");
        drive_txn(SET_PRICE, 4'd9,  4'd5,  4'd0, 1'b0, 4'h0, "bad_type_price");
        drive_txn(QUERY,     4'd0,  4'd4,  4'd0, 1'b0, 4'h0, "bad_type_query4");
        drive_txn(PURCHASE,  4'd12, 4'd15, 4'd1, 1'b0, 4'hC, "bad_type_buy15");
        drive_txn(QUERY,     4'd0,  4'd1,  4'd0, 1'b1, 4'h1, "query_t1_untouched");
        drive_txn(PURCHASE,  4'd8,  4'd1,  4'd0, 1'b0, 4'h8, "buy_t1_zero_qty");
        drive_txn(SET_PRICE, 4'd0,  4'd1,  4'd0, 1'b0, 4'h0, "price_t1_zero");
        drive_txn(PURCHASE,  4'd4,  4'd1,  4'd1, 1'b1, 4'h0, "buy_t1_price_kept");
        drive_txn(RESTOCK,   4'd0,  4'd1,  4'd0, 1'b1, 4'h0, "restock_t1_zero");
        drive_txn(QUERY,     4'd0,  4'd1,  4'd0, 1'b1, 4'h0, "query_t1_empty");
    endtask

    task automatic test_back_to_back();
        drive_txn(SET_PRICE, 4'd15, 4'd2, 4'd0,  1'b1, 4'hF, "price_t2_15");
        drive_txn(RESTOCK,   4'd0,  4'd2, 4'd15, 1'b1, 4'hF, "restock_t2_15");
        drive_txn(PURCHASE,  4'd15, 4'd2, 4'd15, 1'b0, 4'hF, "buy_t2_cost225");
        drive_txn(QUERY,     4'd0,  4'd0, 4'd0,  1'b1, 4'h3, "query_t0_before_rst");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mode         = PURCHASE;
        in_money     = 4'd9;
        product_type = 4'd2;
        number       = 4'd1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (segment !== seg_blank()) begin
            errors++;
            $display("[TB] FAIL midrst_segment actual %h expected %h", segment, seg_blank());
        end
        checks++;
        if (status !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_status actual %0b expected 0", status);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        mode         = QUERY;
        product_type = 4'd0;
        rst          = 1'b0;
        drive_txn(QUERY,    4'd0, 4'd0, 4'd0, 1'b1, 4'h1, "midrst_query_t0");
        drive_txn(QUERY,    4'd0, 4'd2, 4'd0, 1'b1, 4'h1, "midrst_query_t2");
        drive_txn(PURCHASE, 4'd3, 4'd0, 4'd1, 1'b1, 4'h0, "midrst_buy_t0_price3");
        drive_txn(PURCHASE, 4'd6, 4'd3, 4'd1, 1'b1, 4'h0, "midrst_buy_t3_price6");
        drive_txn(PURCHASE, 4'd3, 4'd1, 4'd1, 1'b0, 4'h3, "midrst_buy_t1_price4");
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        rst          = 1'b1;
        mode         = QUERY;
        in_money     = 4'd0;
        product_type = 4'd0;
        number       = 4'd0;

        test_reset();
        test_purchase();
        test_restock();
        test_stock_limit();
        test_set_price();
        test_invalid();
        test_back_to_back();
        test_reset_mid();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_machine.md
# vending_machine

Single-clock vending-machine controller tracking per-product stock and price and processing one transaction per rising clock edge. Transactions are purchase, restock, set price and stock query. The result is reported on a 7-segment digit and a success flag. It sits between the front-panel input logic (coin value, selection, quantity) and the display driver.

## Interface
- `NUM_TYPES`, default 4: number of product slots; valid `type` is 0..NUM_TYPES-1.
- `STOCK_W`, default 6: stock counter width.
- `INIT_STOCK`, default 1: stock of every slot after reset.
- `clk`, in, 1: clock; all state updates on rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `mode`, in, 2: operation; 0 purchase, 1 restock, 2 set price, 3 query stock.
- `in_money`, in, 4: money presented (purchase) or new price (set price).
- `type`, in, 4: product slot selector.
- `number`, in, 4: quantity to buy or quantity to add.
- `segment`, out, 7: hex digit, `segment[0]`=a … `segment[6]`=g, registered.
- `status`, out, 1: 1 = last transaction succeeded, registered.

## Operation
- Reset:
  - every stock = INIT_STOCK.
  - Prices: type0=3, type1=4, type2=5, type3=6; slots ≥4 = 7.
  - `segment` = blank (all segments off).
  - `status` = 0.
- Each rising edge executes exactly one transaction from the sampled inputs; no multi-cycle handshake.
- Invalid `type` (≥NUM_TYPES), any mode:
  - `status`=0; no state change.
  - segment shows `in_money` in purchase mode, else 0.
- Mode 0, purchase:
  - cost = price[type] × number, 8-bit.
  - Success requires number≠0, stock[type] ≥ number and in_money ≥ cost.
  - On success: stock −= number; `status`=1; segment shows change = in_money − cost.
  - On failure: nothing changes; `status`=0; segment shows in_money (full refund).
- Mode 1, restock:
  - stock[type] += number, saturating at 2^STOCK_W−1.
  - `status`=1; segment shows `number`.
  - number=0 is a legal no-op success.
- Mode 2, set price:
  - price[type] = in_money.
  - in_money=0 rejected: `status`=0, price unchanged.
  - Otherwise `status`=1; segment shows the new price.
- Mode 3, query:
  - no state change; `status`=1.
  - segment shows min(stock[type], 15).
- Hex decode (active-high): standard 0-9, A, b, C, d, E, F.

## Timing
- Outputs valid after the edge that samples the inputs (1-cycle latency) and held until the next edge.
- Inputs need only be stable around the rising edge; no combinational input-to-output path.
- Reset mid-transaction: reset wins immediately and asynchronously; the in-flight transaction is discarded.
- First edge after reset deassertion performs a normal transaction.
- Arithmetic is unsigned; cost never truncates (8-bit); change fits 4 bits because change ≤ in_money.

## Configuration
- `VENDING_MACHINE_SEG_ACTIVE_LOW_EN`:
  - When defined, `segment` is inverted (active-low segments). The reset value is then all-ones, i.e. blank.
  - When undefined, segments are active-high and the reset value is all-zeros.
  - Status logic is identical either way.

## Structure
- Package `vending_machine_pkg` holds:
  - mode encoding constants (PURCHASE, RESTOCK, SET_PRICE, QUERY);
  - the default price table;
  - the 16-entry hex-to-segment constant table;
  - the BLANK segment constant.
- One sub-module, `seg7_decoder`: 4-bit value to 7-bit pattern, combinational. Its output is registered in the top level.
- Stock and price arrays plus the transaction decision stay in `vending_machine`.

## Test plan
- Reset, then mode0 type0 number1 in_money9 → status1, segment `6`, stock0 = 0. Repeat the same inputs → status0, segment `9` (empty stock refund).
- Mode1 type0 number15, then mode1 type0 number4 → status1 both, segments `F` then `4`. Mode3 type0 → segment `F` (stock 19 clamped). Drive restock repeatedly → stock saturates at 63.
- Mode0 type3 number2 in_money13 with stock3=1 → status0, segment `d`. After mode1 type3 number1, repeat → status1, segment `1`, stock3 = 0.
- Mode2 type3 in_money2 → status1, segment `2`. Mode0 type3 number1 in_money2 after restock → status1, segment `0`. Mode0 type1 number3 in_money11 (cost 12) → status0, segment `b`.
- Type 5 in any mode → status0, no state change. Mode0 number0 → status0, refund shown. Mode2 in_money0 → status0.
- Assert `rst` asynchronously between edges during a purchase → outputs blank/0 immediately, stocks back to 1, prices to defaults.
